dense_layer_param: RTL and testbench



---
 rtl/dense_layer_param.sv | 252 +++++++++++++++++++++++++
 tb/tb_dense_layer_param.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dense_layer_param.sv
// Fully-connected layer: buffers one frame of activations, runs N_OUT dot products
// through one pipelined MAC, then bias/round/saturate/ReLU onto a valid/ready stream.
module dense_layer_param #(
    parameter int DW       = 16,
    parameter int N_IN     = 128,
    parameter int N_OUT    = 11,
    parameter int FRAC_IN  = 12,
    parameter int FRAC_OUT = 9,
    parameter int ACC_W    = 2*DW + $clog2(N_IN),
    localparam int WA_W    = $clog2(N_IN*N_OUT),
    localparam int BA_W    = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DW-1:0]   din,
    input  logic            din_valid,
    output logic            din_ready,
    input  logic            relu_en,
    output logic [WA_W-1:0] w_addr,
    input  logic [DW-1:0]   w_data,
    output logic [BA_W-1:0] b_addr,
    input  logic [DW-1:0]   b_data,
    output logic [DW-1:0]   dout,
    output logic            dout_valid,
    input  logic            dout_ready,
    output logic            dout_last,
    output logic            dout_sat
);

    localparam int I_W = $clog2(N_IN);
    localparam int S   = 2*FRAC_IN - FRAC_OUT;
    localparam int VW  = ((ACC_W > DW + S) ? ACC_W : DW + S) + 2;
    localparam logic [I_W-1:0]  LAST_I = I_W'(N_IN - 1);
    localparam logic [BA_W-1:0] LAST_J = BA_W'(N_OUT - 1);
    localparam logic [VW-1:0]   RND    = ({{(VW-1){1'b0}}, 1'b1} << S) >> 1;

    typedef enum logic [2:0] {
        S_LOAD, S_COMPUTE, S_DRAIN, S_FINISH, S_OUT, S_NEXT
    } state_t;

    state_t state_r, state_nxt_s;

    logic [I_W-1:0]  i_r;
    logic [BA_W-1:0] j_r;
    logic [DW-1:0]   x_buf_r [N_IN];
    logic            relu_r;

    logic            din_ready_r;
    logic [WA_W-1:0] w_addr_r;
    logic [BA_W-1:0] b_addr_r;
    logic [DW-1:0]   dout_r;
    logic            dout_valid_r;
    logic            dout_last_r;
    logic            dout_sat_r;

    // MAC pipeline: x read aligned with ROM latency, operand regs, product reg, accumulator
    logic [DW-1:0]           x_d1_r;
    logic                    v1_r, f1_r, l1_r;
    logic signed [DW-1:0]    x_q_r, w_q_r;
    logic                    v2_r, f2_r, l2_r;
    logic signed [2*DW-1:0]  prod_r;
    logic                    v3_r, f3_r, l3_r;
    logic signed [ACC_W-1:0] acc_r;

    logic signed [VW-1:0] sum_s, shr_s;
    logic [VW-DW:0]       hi_s;
    logic [DW-1:0]        clip_s, res_s;
    logic                 sat_s;

    assign din_ready  = din_ready_r;
    assign w_addr     = w_addr_r;
    assign b_addr     = b_addr_r;
    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign dout_last  = dout_last_r;
    assign dout_sat   = dout_sat_r;

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_LOAD: begin
                if (din_valid && din_ready_r && (i_r == LAST_I)) begin
                    state_nxt_s = S_COMPUTE;
                end else begin
                    state_nxt_s = S_LOAD;
                end
            end
            S_COMPUTE: begin
                if (i_r == LAST_I) begin
                    state_nxt_s = S_DRAIN;
                end else begin
                    state_nxt_s = S_COMPUTE;
                end
            end
            S_DRAIN: begin
                if (v3_r && l3_r) begin
                    state_nxt_s = S_FINISH;
                end else begin
                    state_nxt_s = S_DRAIN;
                end
            end
            S_FINISH: state_nxt_s = S_OUT;
            S_OUT: begin
                if (dout_valid_r && dout_ready) begin
                    state_nxt_s = S_NEXT;
                end else begin
                    state_nxt_s = S_OUT;
                end
            end
            S_NEXT: begin
                if (j_r == LAST_J) begin
                    state_nxt_s = S_LOAD;
                end else begin
                    state_nxt_s = S_COMPUTE;
                end
            end
            default: state_nxt_s = S_LOAD;
        endcase
    end

    // State, counters, frame buffer and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_LOAD;
            i_r          <= {I_W{1'b0}};
            j_r          <= {BA_W{1'b0}};
            relu_r       <= 1'b0;
            din_ready_r  <= 1'b0;
            w_addr_r     <= {WA_W{1'b0}};
            b_addr_r     <= {BA_W{1'b0}};
            dout_r       <= {DW{1'b0}};
            dout_valid_r <= 1'b0;
            dout_last_r  <= 1'b0;
            dout_sat_r   <= 1'b0;
            for (int k = 0; k < N_IN; k++) begin
                x_buf_r[k] <= {DW{1'b0}};
            end
        end else begin
            state_r     <= state_nxt_s;
            din_ready_r <= (state_nxt_s == S_LOAD);
            case (state_r)
                S_LOAD: begin
                    if (din_valid && din_ready_r) begin
                        x_buf_r[i_r] <= din;
                        if (i_r == LAST_I) begin
                            i_r    <= {I_W{1'b0}};
                            relu_r <= relu_en;
                        end else begin
                            i_r <= i_r + I_W'(1'b1);
                        end
                    end
                end
                S_COMPUTE: begin
                    b_addr_r <= j_r;
                    if (i_r == LAST_I) begin
                        i_r <= {I_W{1'b0}};
                    end else begin
                        i_r      <= i_r + I_W'(1'b1);
                        w_addr_r <= w_addr_r + WA_W'(1'b1);
                    end
                end
                S_NEXT: begin
                    // the next neuron's base address appears only with its first compute cycle
                    if (j_r == LAST_J) begin
                        j_r      <= {BA_W{1'b0}};
                        w_addr_r <= {WA_W{1'b0}};
                    end else begin
                        j_r      <= j_r + BA_W'(1'b1);
                        w_addr_r <= w_addr_r + WA_W'(1'b1);
                    end
                end
                default: begin
                end
            endcase
            if (state_r == S_FINISH) begin
                dout_r       <= res_s;
                dout_sat_r   <= sat_s;
                dout_last_r  <= (j_r == LAST_J);
                dout_valid_r <= 1'b1;
            end else if (dout_valid_r && dout_ready) begin
                dout_valid_r <= 1'b0;
            end
        end
    end

    // MAC pipeline; acc restarts on the first product of every neuron
    always_ff @(posedge clk) begin
        if (rst) begin
            x_d1_r <= {DW{1'b0}};
            v1_r   <= 1'b0;
            f1_r   <= 1'b0;
            l1_r   <= 1'b0;
            x_q_r  <= {DW{1'b0}};
            w_q_r  <= {DW{1'b0}};
            v2_r   <= 1'b0;
            f2_r   <= 1'b0;
            l2_r   <= 1'b0;
            prod_r <= {(2*DW){1'b0}};
            v3_r   <= 1'b0;
            f3_r   <= 1'b0;
            l3_r   <= 1'b0;
            acc_r  <= {ACC_W{1'b0}};
        end else begin
            x_d1_r <= x_buf_r[i_r];
            v1_r   <= (state_r == S_COMPUTE);
            f1_r   <= (i_r == {I_W{1'b0}});
            l1_r   <= (i_r == LAST_I);
            x_q_r  <= x_d1_r;
            w_q_r  <= w_data;
            v2_r   <= v1_r;
            f2_r   <= f1_r;
            l2_r   <= l1_r;
            prod_r <= x_q_r * w_q_r;
            v3_r   <= v2_r;
            f3_r   <= f2_r;
            l3_r   <= l2_r;
            if (v3_r) begin
                if (f3_r) begin
                    acc_r <= {{(ACC_W-2*DW){prod_r[2*DW-1]}}, prod_r};
                end else begin
                    acc_r <= acc_r + {{(ACC_W-2*DW){prod_r[2*DW-1]}}, prod_r};
                end
            end
        end
    end

    // Bias add, half-up rounding, saturation and optional ReLU
    always_comb begin
        sum_s = {{(VW-ACC_W){acc_r[ACC_W-1]}}, acc_r}
              + ({{(VW-DW){b_data[DW-1]}}, b_data} << S)
              + RND;
        shr_s = sum_s >>> S;
        hi_s  = shr_s[VW-1:DW-1];
        if ((&hi_s) || !(|hi_s)) begin
            sat_s  = 1'b0;
            clip_s = shr_s[DW-1:0];
        end else if (shr_s[VW-1]) begin
            sat_s  = 1'b1;
            clip_s = {1'b1, {(DW-1){1'b0}}};
        end else begin
            sat_s  = 1'b1;
            clip_s = {1'b0, {(DW-1){1'b1}}};
        end
        if (relu_r && clip_s[DW-1]) begin
            res_s = {DW{1'b0}};
        end else begin
            res_s = clip_s;
        end
    end

endmodule

// File: tb/tb_dense_layer_param.sv
// Self-checking bench for dense_layer_param (N_IN=4, N_OUT=3): directed and random
// frames against an arithmetic reference model, with ROMs modelled in the bench.
module tb_dense_layer_param;

    localparam int DW = 16, N_IN = 4, N_OUT = 3, FRAC_IN = 12, FRAC_OUT = 9;
    localparam int S = 2*FRAC_IN - FRAC_OUT;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] din;
    logic        din_valid;
    logic        din_ready;
    logic        relu_en;
    logic [3:0]  w_addr;
    logic [15:0] w_data;
    logic [1:0]  b_addr;
    logic [15:0] b_data;
    logic [15:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        dout_last;
    logic        dout_sat;

    logic [15:0] wrom [16];
    logic [15:0] brom [4];
    logic [15:0] xv [N_IN];
    logic [15:0] exp_dout [N_OUT];
    logic        exp_sat [N_OUT];

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    dense_layer_param #(.DW(DW), .N_IN(N_IN), .N_OUT(N_OUT), .FRAC_IN(FRAC_IN), .FRAC_OUT(FRAC_OUT)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .relu_en(relu_en), .w_addr(w_addr), .w_data(w_data), .b_addr(b_addr), .b_data(b_data),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_last(dout_last),
        .dout_sat(dout_sat)
    );

    // Synchronous ROMs with one cycle read latency
    always @(posedge clk) begin
        w_data <= wrom[w_addr];
        b_data <= brom[b_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Latency monitor: first dout_valid of a neuron must come N_IN+4 cycles after its first address
    int cyc = 0, start_cyc = 0;
    logic prev_dr = 1'b0, prev_dv = 1'b0;
    logic [3:0] prev_wa = 4'd0;
    always @(negedge clk) begin
        cyc++;
        if (din_ready === 1'b0 && (prev_dr === 1'b1 || (w_addr !== prev_wa && (w_addr % N_IN) == 0)))
            start_cyc = cyc;
        if (dout_valid === 1'b1 && prev_dv !== 1'b1)
            chk("latency", cyc - start_cyc, N_IN + 4);
        prev_dr = din_ready;
        prev_dv = dout_valid;
        prev_wa = w_addr;
    end

    task automatic model(input bit relu);
        longint acc, v;
        for (int j = 0; j < N_OUT; j++) begin
            acc = 0;
            for (int i = 0; i < N_IN; i++)
                acc += longint'($signed(xv[i])) * longint'($signed(wrom[j*N_IN+i]));
            v = acc + longint'($signed(brom[j])) * (longint'(1) << S) + (longint'(1) << (S-1));
            v = v >>> S;
            exp_sat[j] = 1'b0;
            if (v > 32767) begin v = 32767; exp_sat[j] = 1'b1; end
            else if (v < -32768) begin v = -32768; exp_sat[j] = 1'b1; end
            if (relu && v < 0) v = 0;
            exp_dout[j] = v[15:0];
        end
    endtask

    task automatic set_const(input logic [15:0] x, input logic [15:0] w, input logic [15:0] b);
        for (int i = 0; i < N_IN; i++) xv[i] = x;
        for (int k = 0; k < 16; k++) wrom[k] = w;
        for (int k = 0; k < 4; k++) brom[k] = b;
    endtask

    task automatic load_frame(input bit relu);
        int i, cnt;
        i = 0; cnt = 0;
        relu_en = relu;
        dout_ready = 1'b0;
        while (i < N_IN && cnt < 200) begin
            @(negedge clk); cnt++;
            chk("no_output_in_load", dout_valid, 1'b0);
            din = xv[i];
            din_valid = ($urandom_range(0, 3) != 0);
            if (din_valid && din_ready === 1'b1) i++;
        end
        chk("load_done", i, N_IN);
    endtask

    task automatic collect(input int n_out, input int stall_idx, input int stall_len,
                           input bit rnd_ready, input bit toggle);
        int k, cnt, stalled;
        bit held, exp_drop;
        logic [15:0] hd; logic hs, hl; logic [3:0] hwa;
        k = 0; cnt = 0; stalled = 0; held = 1'b0; exp_drop = 1'b0;
        while (k < n_out && cnt < 400) begin
            @(negedge clk); cnt++;
            if (cnt == 1 && toggle) relu_en = ~relu_en;
            din_valid = 1'b1;
            din = 16'($urandom);
            chk("din_ready_busy", din_ready, 1'b0);
            if (exp_drop) begin chk("valid_drop", dout_valid, 1'b0); exp_drop = 1'b0; end
            if (held) begin
                chk("hold_valid", dout_valid, 1'b1);
                chk("hold_dout", dout, hd);
                chk("hold_sat", dout_sat, hs);
                chk("hold_last", dout_last, hl);
                chk("hold_waddr", w_addr, hwa);
            end
            held = 1'b0;
            if (dout_valid === 1'b1) begin
                if ((k == stall_idx && stalled < stall_len) || (rnd_ready && $urandom_range(0, 2) == 0)) begin
                    dout_ready = 1'b0;
                    held = 1'b1; hd = dout; hs = dout_sat; hl = dout_last; hwa = w_addr;
                    if (k == stall_idx) stalled++;
                end else begin
                    dout_ready = 1'b1;
                    chk("dout", dout, exp_dout[k]);
                    chk("dout_sat", dout_sat, exp_sat[k]);
                    chk("dout_last", dout_last, (k == N_OUT - 1));
                    k++;
                    exp_drop = 1'b1;
                end
            end else begin
                dout_ready = 1'b0;
            end
        end
        chk("outputs_seen", k, n_out);
        @(negedge clk);
        dout_ready = 1'b0;
        din_valid = 1'b0;
        chk("valid_drop", dout_valid, 1'b0);
    endtask

    task automatic run_frame(input bit relu, input bit toggle, input int stall_idx,
                             input int stall_len, input bit rnd_ready);
        model(relu);
        load_frame(relu);
        collect(N_OUT, stall_idx, stall_len, rnd_ready, toggle);
        @(negedge clk);
        chk("back_to_load", din_ready, 1'b1);
    endtask

    initial begin
        int cnt;
        bit r;
        rst = 1'b1; din = 16'd0; din_valid = 1'b0; dout_ready = 1'b0; relu_en = 1'b0;
        set_const(16'h0000, 16'h0000, 16'h0000);
        @(negedge clk); @(negedge clk);
        chk("rst_din_ready", din_ready, 1'b0);
        chk("rst_dout_valid", dout_valid, 1'b0);
        chk("rst_dout", dout, 16'h0000);
        chk("rst_waddr", w_addr, 4'd0);
        chk("rst_baddr", b_addr, 2'd0);
        chk("rst_last_sat", {dout_last, dout_sat}, 2'b00);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_release_ready", din_ready, 1'b1);

        // Nominal
        set_const(16'h1000, 16'h0800, 16'h0000);
        run_frame(1'b0, 1'b0, -1, 0, 1'b0);
        chk("nominal_value", dout, 16'h0400);
        // Bias and rounding
        set_const(16'h1000, 16'h0001, 16'h0200);
        run_frame(1'b0, 1'b0, -1, 0, 1'b0);
        set_const(16'h1000, 16'h0FFF, 16'h0000);
        run_frame(1'b0, 1'b0, -1, 0, 1'b0);
        // Saturation
        set_const(16'h7FFF, 16'h7FFF, 16'h0000);
        run_frame(1'b0, 1'b0, -1, 0, 1'b0);
        chk("sat_pos", {dout_sat, dout}, {1'b1, 16'h7FFF});
        set_const(16'h8000, 16'h7FFF, 16'h0000);
        run_frame(1'b0, 1'b0, -1, 0, 1'b0);
        chk("sat_neg", {dout_sat, dout}, {1'b1, 16'h8000});
        // ReLU on, off, and toggled after frame start
        set_const(16'h1000, 16'hF800, 16'h0000);
        run_frame(1'b1, 1'b0, -1, 0, 1'b0);
        chk("relu_on", dout, 16'h0000);
        run_frame(1'b0, 1'b0, -1, 0, 1'b0);
        chk("relu_off", dout, 16'hFC00);
        run_frame(1'b1, 1'b1, -1, 0, 1'b0);
        run_frame(1'b0, 1'b1, -1, 0, 1'b0);
        // Backpressure on output 1 with distinct per-neuron data
        for (int i = 0; i < N_IN; i++) xv[i] = 16'h0400 * 16'(i + 1);
        for (int k = 0; k < 16; k++) wrom[k] = 16'h0100 * 16'(k + 1);
        brom[0] = 16'h0010; brom[1] = 16'hFF00; brom[2] = 16'h0123; brom[3] = 16'h0000;
        run_frame(1'b0, 1'b0, 1, 10, 1'b0);

        // Reset during compute of output 1
        set_const(16'h1000, 16'h0800, 16'h0100);
        model(1'b0);
        load_frame(1'b0);
        collect(1, -1, 0, 1'b0, 1'b0);
        cnt = 0;
        while (w_addr !== 4'(N_IN + 1) && cnt < 50) begin @(negedge clk); cnt++; end
        chk("reach_compute1", w_addr, 4'(N_IN + 1));
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_din_ready", din_ready, 1'b0);
        chk("mid_rst_valid", dout_valid, 1'b0);
        chk("mid_rst_addrs", {w_addr, b_addr}, 6'd0);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("no_output_after_rst", dout_valid, 1'b0);
        end
        chk("ready_after_rst", din_ready, 1'b1);
        run_frame(1'b0, 1'b0, -1, 0, 1'b0);

        // Random frames with random backpressure
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < N_IN; i++) xv[i] = 16'($urandom);
            for (int k = 0; k < 16; k++)
                wrom[k] = (f % 2 == 0) ? 16'($urandom) : 16'($urandom_range(0, 8191)) - 16'd4096;
            for (int k = 0; k < 4; k++) brom[k] = 16'($urandom);
            r = 1'($urandom_range(0, 1));
            run_frame(r, 1'($urandom_range(0, 1)), $urandom_range(0, N_OUT - 1), $urandom_range(0, 5), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
